jg_lut_judge: RTL and testbench



---
 rtl/jg_lut_judge.sv | 151 +++++++++++++++
 tb/tb_jg_lut_judge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jg_lut_judge.sv
`default_nettype none
// ============================================================================
// Module      : jg_lut_judge
// Description : Programmable lookup-table judge. Mode 0 looks up every valid
//               code directly; mode 1 only emits once a code has been seen
//               QUAL consecutive valid times (gaps in in_valid are ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module jg_lut_judge #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2,
    parameter int QUAL  = 3,
    parameter int HIT_A = 0,
    parameter int HIT_B = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_code,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_code,
    output logic             locked,
    output logic [7:0]       chg_cnt
);

    localparam int         DEPTH  = 1 << IN_W;
    localparam logic [3:0] C_QUAL = 4'(QUAL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_run;
    logic [3:0]       w_run_nxt;
    logic [3:0]       w_run_inc;
    logic [IN_W-1:0]  r_last;
    logic [IN_W-1:0]  w_last_nxt;
    logic             w_q_emit;
    logic             w_upd;
    logic [OUT_W-1:0] w_lookup;
    logic [OUT_W-1:0] r_table [DEPTH];

    // Lookup reads the table before any same-cycle write lands.
    assign w_lookup  = r_table[in_code];
    assign w_run_inc = r_run + 4'd1;
    assign w_upd     = mode ? w_q_emit : in_valid;
    assign locked    = mode && (r_state == ST_LOCKED);

    // Qualification FSM: next state, run counter, last code and emit strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_last_nxt  = r_last;
        w_q_emit    = 1'b0;
        if (!mode) begin
            // Direct mode parks the qualifier so a later switch starts fresh.
            w_state_nxt = ST_IDLE;
            w_run_nxt   = 4'd0;
        end else if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_last_nxt = in_code;
                    w_run_nxt  = 4'd1;
                    if (C_QUAL == 4'd1) begin
                        w_state_nxt = ST_LOCKED;
                        w_q_emit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (in_code == r_last) begin
                        if (w_run_inc >= C_QUAL) begin
                            w_run_nxt   = C_QUAL;
                            w_state_nxt = ST_LOCKED;
                            w_q_emit    = 1'b1;
                        end else begin
                            w_run_nxt = w_run_inc;
                        end
                    end else begin
                        w_last_nxt = in_code;
                        w_run_nxt  = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    // Same code keeps the lock silently; run stays capped.
                    if (in_code != r_last) begin
                        w_last_nxt  = in_code;
                        w_run_nxt   = 4'd1;
                        w_state_nxt = ST_TRACK;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = 4'd0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_run   <= 4'd0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Table storage: reset image has HIT_A and HIT_B set to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= ((i == HIT_A) || (i == HIT_B)) ? OUT_W'(1) : '0;
            end
        end else if (cfg_we) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    // Judged output, update pulse and saturating change counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_code  <= '0;
            out_valid <= 1'b0;
            chg_cnt   <= 8'd0;
        end else begin
            out_valid <= w_upd;
            if (w_upd) begin
                out_code <= w_lookup;
                if ((w_lookup != out_code) && (chg_cnt != 8'hFF)) begin
                    chg_cnt <= chg_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jg_lut_judge.sv
`default_nettype none
// ============================================================================
// Module      : tb_jg_lut_judge
// Description : Self-checking bench for jg_lut_judge with a streak-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jg_lut_judge;

    localparam int QUAL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [1:0] cfg_data = '0;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = '0;
    logic       out_valid;
    logic [1:0] out_code;
    logic       locked;
    logic [7:0] chg_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_tab [8];
    int m_out;
    int m_cnt;
    int m_streak;
    int m_last;
    bit m_ov;

    jg_lut_judge dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .in_valid (in_valid),
        .in_code  (in_code),
        .out_valid(out_valid),
        .out_code (out_code),
        .locked   (locked),
        .chg_cnt  (chg_cnt)
    );

    always #5 clk = ~clk;

    // Model one clock edge from the rules: streak of identical valid codes.
    task automatic model_edge(input bit r, input bit m, input bit we, input int a,
                              input int d, input bit v, input int c);
        int nv;
        bit upd;
        nv  = 0;
        upd = 1'b0;
        if (r) begin
            for (int i = 0; i < 8; i++) m_tab[i] = (i == 0 || i == 5) ? 1 : 0;
            m_out = 0; m_ov = 1'b0; m_cnt = 0; m_streak = 0; m_last = 0;
        end else begin
            if (!m) begin
                m_streak = 0;
                if (v) begin upd = 1'b1; nv = m_tab[c]; end
            end else if (v) begin
                if (m_streak > 0 && c == m_last) m_streak++;
                else begin m_streak = 1; m_last = c; end
                if (m_streak == QUAL) begin upd = 1'b1; nv = m_tab[c]; end
            end
            if (we) m_tab[a] = d;
            m_ov = upd;
            if (upd) begin
                if (nv != m_out && m_cnt < 255) m_cnt++;
                m_out = nv;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, land #1 after the edge.
    task automatic cycle(input bit r, input bit m, input bit we, input int a,
                         input int d, input bit v, input int c);
        rst = r; mode = m; cfg_we = we; cfg_addr = 3'(a); cfg_data = 2'(d);
        in_valid = v; in_code = 3'(c);
        @(posedge clk);
        model_edge(r, m, we, a, d, v, c);
        #1;
    endtask

    task automatic test_reset;
        cycle(1, 0, 1, 0, 3, 1, 0);
        n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_ov got %0b want 0", out_valid); end
        n_checks++; if (out_code !== 2'd0) begin n_err++; $display("FAIL reset_out got %0d want 0", out_code); end
        n_checks++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %0b want 0", locked); end
        n_checks++; if (chg_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", chg_cnt); end
        cycle(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (out_code !== 2'd1) begin n_err++; $display("FAIL reset_nowrite got %0d want 1", out_code); end
    endtask

    task automatic test_direct_sweep;
        int exp_v [8];
        exp_v = '{1, 0, 0, 0, 0, 1, 0, 0};
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 0, 0, 1, k);
            n_checks++;
            if (out_valid !== 1'b1 || out_code !== 2'(exp_v[k])) begin
                n_err++;
                $display("FAIL sweep_%0d got ov=%0b out=%0d want ov=1 out=%0d", k, out_valid, out_code, exp_v[k]);
            end
        end
        n_checks++; if (chg_cnt !== 8'd4) begin n_err++; $display("FAIL sweep_cnt got %0d want 4", chg_cnt); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (out_valid !== 1'b0 || out_code !== 2'd0) begin n_err++; $display("FAIL sweep_hold got ov=%0b out=%0d want ov=0 out=0", out_valid, out_code); end
    endtask

    task automatic test_write_collision;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 3, 2, 1, 3);
        n_checks++; if (out_code !== 2'd0) begin n_err++; $display("FAIL collide_old got %0d want 0", out_code); end
        cycle(0, 0, 0, 0, 0, 1, 3);
        n_checks++; if (out_code !== 2'd2) begin n_err++; $display("FAIL collide_new got %0d want 2", out_code); end
    endtask

    task automatic test_qualify_gap;
        int pulses;
        pulses = 0;
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 5); pulses += int'(out_valid);
        cycle(0, 1, 0, 0, 0, 0, 0); pulses += int'(out_valid);
        cycle(0, 1, 0, 0, 0, 1, 5); pulses += int'(out_valid);
        n_checks++; if (pulses !== 0) begin n_err++; $display("FAIL gap_early got %0d pulses want 0", pulses); end
        cycle(0, 1, 0, 0, 0, 1, 5);
        n_checks++; if (out_valid !== 1'b1 || out_code !== 2'd1 || locked !== 1'b1) begin n_err++; $display("FAIL gap_lock got ov=%0b out=%0d lk=%0b want 1,1,1", out_valid, out_code, locked); end
        // Writing the locked code's entry must not disturb the held output.
        cycle(0, 1, 1, 5, 3, 1, 5);
        cycle(0, 1, 0, 0, 0, 1, 5);
        n_checks++; if (out_valid !== 1'b0 || out_code !== 2'd1 || locked !== 1'b1) begin n_err++; $display("FAIL gap_hold got ov=%0b out=%0d lk=%0b want 0,1,1", out_valid, out_code, locked); end
    endtask

    task automatic test_sequence;
        int seq [6];
        int pulses;
        seq = '{5, 5, 2, 5, 5, 5};
        pulses = 0;
        cycle(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 0, 0, 0, 1, seq[k]);
            pulses += int'(out_valid);
        end
        n_checks++; if (pulses !== 0) begin n_err++; $display("FAIL seq_early got %0d pulses want 0", pulses); end
        cycle(0, 1, 0, 0, 0, 1, seq[5]);
        n_checks++; if (out_valid !== 1'b1 || out_code !== 2'd1 || locked !== 1'b1) begin n_err++; $display("FAIL seq_sixth got ov=%0b out=%0d lk=%0b want 1,1,1", out_valid, out_code, locked); end
        cycle(0, 1, 0, 0, 0, 1, 2);
        n_checks++; if (locked !== 1'b0 || out_code !== 2'd1) begin n_err++; $display("FAIL seq_drop got lk=%0b out=%0d want 0,1", locked, out_code); end
        cycle(0, 1, 0, 0, 0, 1, 2);
        cycle(0, 1, 0, 0, 0, 1, 2);
        n_checks++; if (out_valid !== 1'b1 || out_code !== 2'd0 || chg_cnt !== 8'd2) begin n_err++; $display("FAIL seq_relock got ov=%0b out=%0d cnt=%0d want 1,0,2", out_valid, out_code, chg_cnt); end
        cycle(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (locked !== 1'b0 || out_code !== 2'd0 || chg_cnt !== 8'd2) begin n_err++; $display("FAIL seq_mode0 got lk=%0b out=%0d cnt=%0d want 0,0,2", locked, out_code, chg_cnt); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 5);
        cycle(0, 1, 0, 0, 0, 1, 5);
        cycle(1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 5); pulses += int'(out_valid);
        cycle(0, 1, 0, 0, 0, 1, 5); pulses += int'(out_valid);
        n_checks++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_early got %0d pulses want 0", pulses); end
        cycle(0, 1, 0, 0, 0, 1, 5);
        n_checks++; if (out_valid !== 1'b1 || out_code !== 2'd1) begin n_err++; $display("FAIL rstmid_third got ov=%0b out=%0d want 1,1", out_valid, out_code); end
    endtask

    task automatic test_saturate;
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 254; k++) cycle(0, 0, 0, 0, 0, 1, k % 2);
        n_checks++; if (chg_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254 got %0d want 254", chg_cnt); end
        for (int k = 254; k < 310; k++) cycle(0, 0, 0, 0, 0, 1, k % 2);
        n_checks++; if (chg_cnt !== 8'd255) begin n_err++; $display("FAIL sat_255 got %0d want 255", chg_cnt); end
    endtask

    task automatic test_random;
        bit m;
        bit r;
        bit we;
        bit v;
        int c;
        int e_lk;
        m = 1'b1;
        cycle(1, m, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            r  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) m = ~m;
            we = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : (($urandom_range(0, 1) == 0) ? 2 : 5);
            cycle(r, m, we, $urandom_range(0, 7), $urandom_range(0, 3), v, c);
            e_lk = (mode && m_streak >= QUAL) ? 1 : 0;
            n_checks++; if (out_valid !== m_ov) begin n_err++; $display("FAIL rnd_ov@%0d got %0b want %0b", k, out_valid, m_ov); end
            n_checks++; if (out_code !== 2'(m_out)) begin n_err++; $display("FAIL rnd_out@%0d got %0d want %0d", k, out_code, m_out); end
            n_checks++; if (locked !== 1'(e_lk)) begin n_err++; $display("FAIL rnd_lk@%0d got %0b want %0d", k, locked, e_lk); end
            n_checks++; if (chg_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt@%0d got %0d want %0d", k, chg_cnt, m_cnt); end
        end
    endtask

    initial begin
        test_reset;
        test_direct_sweep;
        test_write_collision;
        test_qualify_gap;
        test_sequence;
        test_reset_mid;
        test_saturate;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
